// File: rtl/anf_degree_scan_if.sv
// Handshake bundle between the Moebius transform output and the ANF degree scanner.
// The upstream transform side and the downstream result consumer are both modelled
// by the master modport; the scanner itself uses the slave modport.
interface anf_degree_scan_if #(
    parameter int N      = 256,
    parameter int LOG2_N = 8
) ();
    logic              in_valid;
    logic              in_ready;
    logic [0:N-1]      in_coeffs;
    logic              out_valid;
    logic              out_ready;
    logic [LOG2_N:0]   out_degree;
    logic [LOG2_N:0]   out_weight;
    logic              out_zero;

    modport master (
        output in_valid, in_coeffs, out_ready,
        input  in_ready, out_valid, out_degree, out_weight, out_zero
    );

    modport slave (
        input  in_valid, in_coeffs, out_ready,
        output in_ready, out_valid, out_degree, out_weight, out_zero
    );
endinterface

// File: rtl/anf_degree_scan.sv
// Captures one ANF coefficient vector and scans it W coefficients per cycle,
// producing the algebraic degree (max popcount of any present monomial index),
// the monomial count and an all-zero flag. All outputs are flops so nothing
// downstream sees a combinational path from the handshake inputs.
module anf_degree_scan #(
    parameter int N      = 256,
    parameter int LOG2_N = 8,
    parameter int W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    anf_degree_scan_if.slave      bus
);
    localparam int NCHUNK = N / W;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [0:N-1]      cap_q, cap_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [LOG2_N:0]   deg_acc_q, deg_acc_d;
    logic [LOG2_N:0]   wt_acc_q, wt_acc_d;
    logic [LOG2_N:0]   out_deg_q, out_deg_d;
    logic [LOG2_N:0]   out_wt_q, out_wt_d;
    logic              out_zero_q, out_zero_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;

    logic [LOG2_N:0]   chunk_deg_s;
    logic [LOG2_N:0]   chunk_wt_s;
    logic [LOG2_N-1:0] idx_s;
    logic              accept_s;

    // Number of variables in monomial idx, i.e. its degree.
    function automatic logic [LOG2_N:0] popcount(input logic [LOG2_N-1:0] v);
        logic [LOG2_N:0] s;
        s = '0;
        for (int k = 0; k < LOG2_N; k++) begin
            s = s + {{LOG2_N{1'b0}}, v[k]};
        end
        return s;
    endfunction

    // Degree and weight contribution of the chunk currently addressed by cnt_q.
    always_comb begin
        chunk_deg_s = '0;
        chunk_wt_s  = '0;
        idx_s       = '0;
        for (int j = 0; j < W; j++) begin
            idx_s = LOG2_N'(int'(cnt_q) * W + j);
            if (cap_q[idx_s]) begin
                chunk_wt_s = chunk_wt_s + (LOG2_N+1)'(1);
                if (popcount(idx_s) > chunk_deg_s) begin
                    chunk_deg_s = popcount(idx_s);
                end else begin
                    chunk_deg_s = chunk_deg_s;
                end
            end else begin
                chunk_wt_s = chunk_wt_s;
            end
        end
    end

    // in_ready_q is only high while idle, so it alone qualifies the accept.
    assign accept_s = bus.in_valid && in_ready_q && (state_q == IDLE);

    // Next-state, accumulator and result-register update logic.
    always_comb begin
        state_d    = state_q;
        cap_d      = cap_q;
        cnt_d      = cnt_q;
        deg_acc_d  = deg_acc_q;
        wt_acc_d   = wt_acc_q;
        out_deg_d  = out_deg_q;
        out_wt_d   = out_wt_q;
        out_zero_d = out_zero_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    cap_d     = bus.in_coeffs;
                    cnt_d     = '0;
                    deg_acc_d = '0;
                    wt_acc_d  = '0;
                    state_d   = SCAN;
                end else begin
                    state_d   = IDLE;
                end
            end
            SCAN: begin
                deg_acc_d = (chunk_deg_s > deg_acc_q) ? chunk_deg_s : deg_acc_q;
                wt_acc_d  = wt_acc_q + chunk_wt_s;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == LAST_CHUNK) begin
                    state_d    = DONE;
                    out_deg_d  = deg_acc_d;
                    out_wt_d   = wt_acc_d;
                    out_zero_d = (wt_acc_d == '0);
                end else begin
                    state_d    = SCAN;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Handshake flags follow the next state so they change on the same edge.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered outputs; all cleared while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q       <= '0;
            cnt_q       <= '0;
            deg_acc_q   <= '0;
            wt_acc_q    <= '0;
            out_deg_q   <= '0;
            out_wt_q    <= '0;
            out_zero_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            cap_q       <= cap_d;
            cnt_q       <= cnt_d;
            deg_acc_q   <= deg_acc_d;
            wt_acc_q    <= wt_acc_d;
            out_deg_q   <= out_deg_d;
            out_wt_q    <= out_wt_d;
            out_zero_q  <= out_zero_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_degree = out_deg_q;
    assign bus.out_weight = out_wt_q;
    assign bus.out_zero   = out_zero_q;
endmodule
